// File: rtl/ddr3_avl_arbiter_if.sv
// rtl/ddr3_avl_arbiter_if.sv - Avalon-MM local bus between the arbiter and the DDR3 controller
// Purpose: groups the avl_* command, write-data and read-return signals.
// Ports (master = arbiter side):
//   ready       waitrequest_n from the controller
//   burstbegin  beginbursttransfer, first cycle of a burst only
//   addr/size   word address and burstcount
//   wdata/be    write data and byte enables
//   write_req   write command / beat strobe
//   read_req    read command
//   rdata_valid readdatavalid from the controller
//   rdata       readdata from the controller
interface ddr3_avl_arbiter_if #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 3
);
  logic                  ready;
  logic                  burstbegin;
  logic [ADDR_W-1:0]     addr;
  logic [BURST_W-1:0]    size;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic                  write_req;
  logic                  read_req;
  logic                  rdata_valid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    input  ready, rdata_valid, rdata,
    output burstbegin, addr, size, wdata, be, write_req, read_req
  );

  modport slave (
    output ready, rdata_valid, rdata,
    input  burstbegin, addr, size, wdata, be, write_req, read_req
  );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// rtl/ddr3_avl_arbiter.sv - round-robin write/read burst scheduler for the DDR3 Avalon-MM local interface
// Purpose: grants one of two burst requesters at a time, runs the per-beat write
//   handshake and returns read data, so requesters never drive the avl bus.
// Ports:
//   afi_clk, rst          clock and synchronous active-high reset
//   local_cal_success     arbitration enable
//   wr_req/addr/size      write burst request (addr/size sampled at grant)
//   wr_data, wr_data_ack  show-ahead FIFO head and its pop strobe
//   wr_done               last write beat accepted
//   rd_req/addr/size      read burst request (addr/size sampled at grant)
//   rd_data, rd_data_valid, rd_done  registered read return
//   busy                  a transaction is in progress
//   avl                   Avalon-MM master side
module ddr3_avl_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 3
) (
  input  logic                 afi_clk,
  input  logic                 rst,
  input  logic                 local_cal_success,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BURST_W-1:0]   wr_size,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_data_ack,
  output logic                 wr_done,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [BURST_W-1:0]   rd_size,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_data_valid,
  output logic                 rd_done,
  output logic                 busy,
  ddr3_avl_arbiter_if.master   avl
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_CMD, RD_WAIT} state_t;

  state_t               state, state_nxt;
  logic                 last_grant_rd;   // 1: read was granted last
  logic                 first_q;         // first cycle of the current burst
  logic [ADDR_W-1:0]    addr_q;
  logic [BURST_W-1:0]   size_q;
  logic [BURST_W-1:0]   beat_cnt;
  logic [BURST_W-1:0]   cnt_inc;
  logic                 cnt_last;
  logic                 arb_en, grant_wr, grant_rd, rd_beat;

  logic                 burstbegin_c, write_req_c, read_req_c;
  logic [ADDR_W-1:0]    addr_c;
  logic [BURST_W-1:0]   size_c;
  logic [DATA_W-1:0]    wdata_c;

  assign cnt_inc  = beat_cnt + BURST_W'(1);
  assign cnt_last = (cnt_inc == size_q);
  assign rd_beat  = avl.rdata_valid && (state == RD_CMD || state == RD_WAIT);

  // rd_done is registered and lands in the first IDLE cycle after a read; the
  // read requester only drops rd_req at the end of that cycle, so arbitration
  // is held off for it to avoid re-granting a stale request.
  assign arb_en   = (state == IDLE) && local_cal_success && !rd_done;
  assign grant_wr = arb_en && wr_req && (!rd_req || last_grant_rd);
  assign grant_rd = arb_en && rd_req && !grant_wr;

  always_ff @(posedge afi_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    wr_data_ack  = 1'b0;
    wr_done      = 1'b0;
    burstbegin_c = 1'b0;
    write_req_c  = 1'b0;
    read_req_c   = 1'b0;
    addr_c       = '0;
    size_c       = '0;
    wdata_c      = '0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_wr)      state_nxt = WR_BURST;
        else if (grant_rd) state_nxt = RD_CMD;
      end
      WR_BURST: begin
        write_req_c  = 1'b1;
        burstbegin_c = first_q;
        addr_c       = addr_q;
        size_c       = size_q;
        wdata_c      = wr_data;
        if (avl.ready) begin
          wr_data_ack = 1'b1;
          if (cnt_last) begin
            wr_done   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      RD_CMD: begin
        read_req_c   = 1'b1;
        burstbegin_c = first_q;
        addr_c       = addr_q;
        size_c       = size_q;
        // A single-beat read can complete in its own accept cycle.
        if (avl.ready) state_nxt = (rd_beat && cnt_last) ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_beat && cnt_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge afi_clk) begin
    if (rst) begin
      last_grant_rd <= 1'b1;
      first_q       <= 1'b0;
      addr_q        <= '0;
      size_q        <= '0;
      beat_cnt      <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      rd_data_valid <= rd_beat;
      rd_done       <= rd_beat && cnt_last;
      if (rd_beat) rd_data <= avl.rdata;

      if (grant_wr || grant_rd) begin
        addr_q        <= grant_wr ? wr_addr : rd_addr;
        size_q        <= grant_wr ? ((wr_size == '0) ? BURST_W'(1) : wr_size)
                                  : ((rd_size == '0) ? BURST_W'(1) : rd_size);
        beat_cnt      <= '0;
        first_q       <= 1'b1;
        last_grant_rd <= grant_rd;
      end else begin
        if (state != IDLE) first_q <= 1'b0;
        if (wr_data_ack || rd_beat) beat_cnt <= cnt_inc;
      end
    end
  end

  assign avl.burstbegin = burstbegin_c;
  assign avl.write_req  = write_req_c;
  assign avl.read_req   = read_req_c;
  assign avl.addr       = addr_c;
  assign avl.size       = size_c;
  assign avl.wdata      = wdata_c;
  assign avl.be         = '1;

endmodule
